// File: rtl/softmax_sched_if.sv
// Handshake bundle between requesters, the softmax datapath and the response sink.
// The scheduler takes the slave modport; the environment drives the master side.
interface softmax_sched_if #(
  parameter int LANES = 16,
  parameter int DW    = 8
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [LANES*DW-1:0]   req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [LANES*DW-1:0]   req1_data;
  logic [LANES*DW-1:0]   sm_data_in;
  logic                  sm_start;
  logic                  sm_out_valid;
  logic [LANES*DW-1:0]   sm_out_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [LANES*DW-1:0]   rsp_data;
  logic                  rsp_timeout;
  logic                  busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    input  sm_out_valid, sm_out_data, rsp_ready,
    output req0_ready, req1_ready, sm_data_in, sm_start,
    output rsp_valid, rsp_id, rsp_data, rsp_timeout, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    output sm_out_valid, sm_out_data, rsp_ready,
    input  req0_ready, req1_ready, sm_data_in, sm_start,
    input  rsp_valid, rsp_id, rsp_data, rsp_timeout, busy
  );
endinterface

// File: rtl/softmax_sched.sv
// Two-requester round-robin scheduler feeding a single softmax datapath,
// one job in flight, with a WAIT watchdog that turns a stalled job into an abort response.
module softmax_sched #(
  parameter int LANES   = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input logic             clock,
  input logic             reset,
  softmax_sched_if.slave  bus
);
  localparam int          W        = LANES * DW;
  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t         state_reg;
  logic [W-1:0]   operand_reg;
  logic [W-1:0]   rsp_data_reg;
  logic [7:0]     cnt_reg;
  logic           sm_start_reg;
  logic           rsp_valid_reg;
  logic           rsp_timeout_reg;
  logic           rsp_id_reg;
  logic           last_grant_reg;

  logic           grant;
  logic           accept;

  // With a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant = ~last_grant_reg;
    else if (bus.req1_valid)
      grant = 1'b1;
  end

  assign bus.req0_ready = (state_reg == IDLE) && bus.req0_valid && !grant;
  assign bus.req1_ready = (state_reg == IDLE) && bus.req1_valid && grant;
  assign accept         = bus.req0_ready || bus.req1_ready;

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign bus.sm_data_in[DW*gi +: DW] = operand_reg[DW*gi +: DW];
    end
  endgenerate

  assign bus.sm_start    = sm_start_reg;
  assign bus.rsp_valid   = rsp_valid_reg;
  assign bus.rsp_id      = rsp_id_reg;
  assign bus.rsp_data    = rsp_data_reg;
  assign bus.rsp_timeout = rsp_timeout_reg;
  assign bus.busy        = (state_reg != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg       <= IDLE;
      operand_reg     <= '0;
      rsp_data_reg    <= '0;
      cnt_reg         <= '0;
      sm_start_reg    <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      rsp_id_reg      <= 1'b0;
      last_grant_reg  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            operand_reg  <= grant ? bus.req1_data : bus.req0_data;
            rsp_id_reg   <= grant;
            sm_start_reg <= 1'b1;
            state_reg    <= ISSUE;
          end
        end
        ISSUE: begin
          sm_start_reg <= 1'b0;
          cnt_reg      <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          // A real result beats the watchdog when both land on the same cycle.
          if (bus.sm_out_valid) begin
            rsp_data_reg    <= bus.sm_out_data;
            rsp_timeout_reg <= 1'b0;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESP;
          end else if (cnt_reg == CNT_LAST) begin
            rsp_data_reg    <= '0;
            rsp_timeout_reg <= 1'b1;
            rsp_valid_reg   <= 1'b1;
            state_reg       <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_reg  <= 1'b0;
            last_grant_reg <= rsp_id_reg;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_sched.sv
// Directed bench for softmax_sched (TIMEOUT=4): single job, contention, timeout,
// backpressure, coincidence of result and watchdog, and reset mid-WAIT.
module tb_softmax_sched;
  localparam int LANES = 16;
  localparam int DW    = 8;
  localparam int W     = LANES * DW;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total  = 0;
  int   passes = 0;
  int   start_cnt = 0;
  int   base;

  softmax_sched_if #(.LANES(LANES), .DW(DW)) bus ();

  softmax_sched #(.LANES(LANES), .DW(DW), .TIMEOUT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bus.sm_start === 1'b1) start_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    logic [W-1:0] row0, row1, exp_row;
    byte b0, b1;

    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_data = '0; bus.req1_data = '0;
    bus.sm_out_valid = 0; bus.sm_out_data = '0; bus.rsp_ready = 0;

    // Reset state
    tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_sm_start", bus.sm_start, 0);
    check("rst_sm_data_in", bus.sm_data_in, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", bus.rsp_id, 0);
    check("rst_rsp_timeout", bus.rsp_timeout, 0);
    reset = 1;
    tick();

    // Single job: row 0x10, result 0x01 two cycles after sm_start
    base = start_cnt;
    bus.req0_valid = 1; bus.req0_data = {LANES{8'h10}};
    #1;
    check("single_ready0", bus.req0_ready, 1);
    check("single_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0;
    check("single_start", bus.sm_start, 1);
    check("single_busy", bus.busy, 1);
    check("single_operand", bus.sm_data_in, {LANES{8'h10}});
    tick();
    check("single_start_low", bus.sm_start, 0);
    tick();
    bus.sm_out_valid = 1; bus.sm_out_data = {LANES{8'h01}};
    check("single_no_rsp_yet", bus.rsp_valid, 0);
    tick();
    bus.sm_out_valid = 0;
    check("single_rsp_valid", bus.rsp_valid, 1);
    check("single_rsp_id", bus.rsp_id, 0);
    check("single_rsp_data", bus.rsp_data, {LANES{8'h01}});
    check("single_rsp_timeout", bus.rsp_timeout, 0);
    check("single_one_start", start_cnt - base, 1);
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;
    check("single_idle_rsp", bus.rsp_valid, 0);
    check("single_idle_busy", bus.busy, 0);

    // Contention after reset: grant order 0,1,0,1
    reset = 0; tick(); reset = 1;
    bus.req0_valid = 1; bus.req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      b0 = 8'hA0 + 8'(k); b1 = 8'hB0 + 8'(k);
      row0 = {LANES{b0}}; row1 = {LANES{b1}};
      bus.req0_data = row0; bus.req1_data = row1;
      exp_row = (k % 2 == 0) ? row0 : row1;
      #1;
      check($sformatf("cont%0d_ready0", k), bus.req0_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("cont%0d_ready1", k), bus.req1_ready, (k % 2 == 1) ? 1 : 0);
      tick();
      check($sformatf("cont%0d_operand", k), bus.sm_data_in, exp_row);
      check($sformatf("cont%0d_issue_ready", k), {bus.req0_ready, bus.req1_ready}, 0);
      tick();
      bus.req0_data = ~row0; bus.req1_data = ~row1;
      #1;
      check($sformatf("cont%0d_operand_stable", k), bus.sm_data_in, exp_row);
      bus.sm_out_valid = 1; bus.sm_out_data = {LANES{8'h42}};
      tick();
      bus.sm_out_valid = 0;
      check($sformatf("cont%0d_resp_ready", k), {bus.req0_ready, bus.req1_ready}, 0);
      check($sformatf("cont%0d_rsp_id", k), bus.rsp_id, (k % 2 == 0) ? 0 : 1);
      bus.rsp_ready = 1;
      tick();
      bus.rsp_ready = 0;
    end
    bus.req0_valid = 0; bus.req1_valid = 0;

    // Timeout with TIMEOUT=4: req1 alone, no result
    bus.req1_valid = 1; bus.req1_data = {LANES{8'h5A}};
    #1;
    check("to_ready1", bus.req1_ready, 1);
    check("to_ready0", bus.req0_ready, 0);
    tick();
    bus.req1_valid = 0;
    check("to_start", bus.sm_start, 1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("to_wait_c%0d", c), bus.rsp_valid, 0);
    end
    tick();
    check("to_rsp_valid_c5", bus.rsp_valid, 1);
    check("to_rsp_timeout", bus.rsp_timeout, 1);
    check("to_rsp_data", bus.rsp_data, 0);
    check("to_rsp_id", bus.rsp_id, 1);
    bus.sm_out_valid = 1; bus.sm_out_data = {LANES{8'hFF}};
    tick();
    bus.sm_out_valid = 0;
    check("to_late_data", bus.rsp_data, 0);
    check("to_late_timeout", bus.rsp_timeout, 1);
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;

    // Backpressure: tie after req1 served -> req0, rsp_ready low 10 cycles
    base = start_cnt;
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_data = {LANES{8'hC3}}; bus.req1_data = {LANES{8'h3C}};
    #1;
    check("bp_ready0", bus.req0_ready, 1);
    tick();
    tick();
    bus.sm_out_valid = 1; bus.sm_out_data = {LANES{8'h33}};
    tick();
    bus.sm_out_valid = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("bp%0d_valid", c), bus.rsp_valid, 1);
      check($sformatf("bp%0d_data", c), bus.rsp_data, {LANES{8'h33}});
      check($sformatf("bp%0d_id", c), bus.rsp_id, 0);
      check($sformatf("bp%0d_readies", c), {bus.req0_ready, bus.req1_ready}, 0);
    end
    check("bp_one_start", start_cnt - base, 1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;

    // Coincidence: result arrives on the cycle the counter hits TIMEOUT-1
    bus.req0_valid = 1; bus.req0_data = {LANES{8'h21}};
    tick();
    bus.req0_valid = 0;
    for (int c = 1; c <= 4; c++) tick();
    bus.sm_out_valid = 1; bus.sm_out_data = {LANES{8'h77}};
    tick();
    bus.sm_out_valid = 0;
    check("coin_rsp_valid", bus.rsp_valid, 1);
    check("coin_timeout", bus.rsp_timeout, 0);
    check("coin_data", bus.rsp_data, {LANES{8'h77}});
    bus.rsp_ready = 1;
    tick();
    bus.rsp_ready = 0;

    // Reset mid-WAIT, then a stray result; next tie goes to req0
    bus.req1_valid = 1; bus.req1_data = {LANES{8'h66}};
    tick();
    bus.req1_valid = 0;
    tick();
    check("rw_busy_before", bus.busy, 1);
    reset = 0;
    tick();
    reset = 1;
    check("rw_busy", bus.busy, 0);
    check("rw_rsp_valid", bus.rsp_valid, 0);
    check("rw_operand", bus.sm_data_in, 0);
    bus.sm_out_valid = 1; bus.sm_out_data = {LANES{8'h99}};
    tick();
    bus.sm_out_valid = 0;
    check("rw_stray_rsp", bus.rsp_valid, 0);
    check("rw_stray_busy", bus.busy, 0);
    tick();
    check("rw_rsp_data", bus.rsp_data, 0);
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_data = {LANES{8'h0F}}; bus.req1_data = {LANES{8'hF0}};
    #1;
    check("rw_tie_ready0", bus.req0_ready, 1);
    check("rw_tie_ready1", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 0; bus.req1_valid = 0;
    check("rw_tie_operand", bus.sm_data_in, {LANES{8'h0F}});

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
